onehot_scan_decoder: RTL and testbench

//  Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a scan mode.

---
 rtl/onehot_scan_decoder.sv | 90 +++++++++
 tb/tb_onehot_scan_decoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT (latched index) and SCAN (walking bit) modes.
// Optional `ONEHOT_WRAP_PULSE_EN adds a one-cycle wrap strobe aligned with a wrapping scan step.
module onehot_scan_decoder #(
   parameter  int SEL_W    = 3,
   parameter  int SCAN_DIV = 4,
   parameter  int DIV_W    = 8,
   localparam int OUT_W    = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic             mode,
   input  logic             dir,
   input  logic [SEL_W-1:0] Din,
   output logic [OUT_W-1:0] Dout,
   output logic             dout_valid,
`ifdef ONEHOT_WRAP_PULSE_EN
   output logic             wrap,
`endif
   output logic [SEL_W-1:0] scan_idx
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DIRECT = 2'd1;
   localparam logic [1:0] SCAN   = 2'd2;

   localparam logic [OUT_W-1:0] ONE_HOT_LSB = OUT_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);

   logic [1:0]       state;
   logic [DIV_W-1:0] div;
   logic [SEL_W-1:0] step_idx;
   logic             step_wraps;

   // dir is live: it is read at the step edge, not latched at load.
   always_comb begin
      step_idx   = scan_idx;
      step_wraps = 1'b0;
      if (dir) begin
         step_idx   = scan_idx - SEL_W'(1);
         step_wraps = (scan_idx == '0);
      end else begin
         step_idx   = scan_idx + SEL_W'(1);
         step_wraps = (scan_idx == '1);
      end
   end

   // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         div        <= '0;
         scan_idx   <= '0;
         Dout       <= '0;
         dout_valid <= 1'b0;
      end else if (!en) begin
         state      <= IDLE;
         div        <= '0;
         Dout       <= '0;
         dout_valid <= 1'b0;
      end else if (load) begin
         state      <= mode ? SCAN : DIRECT;
         div        <= '0;
         scan_idx   <= Din;
         Dout       <= ONE_HOT_LSB << Din;
         dout_valid <= 1'b1;
      end else if (state == SCAN) begin
         if (div == DIV_LAST) begin
            div      <= '0;
            scan_idx <= step_idx;
            Dout     <= ONE_HOT_LSB << step_idx;
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

`ifdef ONEHOT_WRAP_PULSE_EN
   // Only a free-running scan step can raise wrap; load and en=0 always clear it.
   always_ff @(posedge clk) begin
      if (!rst_n || !en || load) begin
         wrap <= 1'b0;
      end else begin
         wrap <= (state == SCAN) && (div == DIV_LAST) && step_wraps;
      end
   end
`endif

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder (SEL_W=3, SCAN_DIV=4): driver queues hand-computed
// expectations per cycle, a monitor pops and compares them one clock later.
module tb_onehot_scan_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, load = 1'b0, mode = 1'b0, dir = 1'b0;
   logic [2:0] din = '0;
   logic [7:0] dout;
   logic       dout_valid;
   logic [2:0] scan_idx;
   logic       wrap_obs;

   typedef struct {
      string      name;
      logic [7:0] dout;
      logic       valid;
      logic [2:0] idx;
      logic       wrap;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   onehot_scan_decoder #(.SEL_W(3), .SCAN_DIV(4), .DIV_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load       (load),
      .mode       (mode),
      .dir        (dir),
      .Din        (din),
      .Dout       (dout),
      .dout_valid (dout_valid),
`ifdef ONEHOT_WRAP_PULSE_EN
      .wrap       (wrap_obs),
`endif
      .scan_idx   (scan_idx)
   );

`ifndef ONEHOT_WRAP_PULSE_EN
   assign wrap_obs = 1'b0;
`endif

   // Monitor: every cycle with a pending expectation is compared just after the edge.
   initial begin
      exp_t e;
      logic ok;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            ok = (dout === e.dout) && (dout_valid === e.valid) && (scan_idx === e.idx);
`ifdef ONEHOT_WRAP_PULSE_EN
            ok = ok && (wrap_obs === e.wrap);
`endif
            if (!ok) begin
               n_bad++;
               $display("FAIL %s: got dout=%h valid=%b idx=%0d wrap=%b, want dout=%h valid=%b idx=%0d wrap=%b",
                        e.name, dout, dout_valid, scan_idx, wrap_obs, e.dout, e.valid, e.idx, e.wrap);
            end
         end
      end
   end

   task automatic cyc(input string nm, input logic r, input logic e, input logic l, input logic m,
                      input logic d, input logic [2:0] di, input logic [7:0] xd, input logic xv,
                      input logic [2:0] xi, input logic xw);
      exp_t x;
      @(negedge clk);
      rst_n = r; en = e; load = l; mode = m; dir = d; din = di;
      x.name = nm; x.dout = xd; x.valid = xv; x.idx = xi; x.wrap = xw;
      sb.push_back(x);
      @(posedge clk);
   endtask

   // n cycles with en=1 and no load; outputs expected unchanged.
   task automatic hold(input string nm, input int n, input logic d, input logic [7:0] xd,
                       input logic xv, input logic [2:0] xi);
      for (int i = 0; i < n; i++) cyc(nm, 1'b1, 1'b1, 1'b0, 1'b0, d, 3'd2, xd, xv, xi, 1'b0);
   endtask

   initial begin
      // 1: reset overrides en/load
      cyc("reset0", 0, 1, 1, 0, 0, 3'd5, 8'h00, 0, 3'd0, 0);
      cyc("reset1", 0, 1, 1, 0, 0, 3'd5, 8'h00, 0, 3'd0, 0);
      hold("idle_after_reset", 2, 0, 8'h00, 0, 3'd0);

      // 2: DIRECT load, long hold, reload
      cyc("direct_load5", 1, 1, 1, 0, 0, 3'd5, 8'h20, 1, 3'd5, 0);
      hold("direct_hold", 20, 0, 8'h20, 1, 3'd5);
      cyc("direct_load0", 1, 1, 1, 0, 0, 3'd0, 8'h01, 1, 3'd0, 0);

      // 3: SCAN up from 6 with wrap 7->0
      cyc("scanup_load6", 1, 1, 1, 1, 0, 3'd6, 8'h40, 1, 3'd6, 0);
      hold("scanup_dwell6", 3, 0, 8'h40, 1, 3'd6);
      cyc("scanup_step7", 1, 1, 0, 0, 0, 3'd0, 8'h80, 1, 3'd7, 0);
      hold("scanup_dwell7", 3, 0, 8'h80, 1, 3'd7);
      cyc("scanup_wrap0", 1, 1, 0, 0, 0, 3'd0, 8'h01, 1, 3'd0, 1);
      hold("scanup_dwell0", 3, 0, 8'h01, 1, 3'd0);
      cyc("scanup_step1", 1, 1, 0, 0, 0, 3'd0, 8'h02, 1, 3'd1, 0);

      // 4: SCAN down from 1, wrap 0->7, then dir flip mid-dwell
      cyc("scandn_load1", 1, 1, 1, 1, 1, 3'd1, 8'h02, 1, 3'd1, 0);
      hold("scandn_dwell1", 3, 1, 8'h02, 1, 3'd1);
      cyc("scandn_step0", 1, 1, 0, 0, 1, 3'd0, 8'h01, 1, 3'd0, 0);
      hold("scandn_dwell0", 3, 1, 8'h01, 1, 3'd0);
      cyc("scandn_wrap7", 1, 1, 0, 0, 1, 3'd0, 8'h80, 1, 3'd7, 1);
      hold("flip_dwell_dn", 1, 1, 8'h80, 1, 3'd7);
      hold("flip_dwell_up", 2, 0, 8'h80, 1, 3'd7);
      cyc("flip_step_up0", 1, 1, 0, 0, 0, 3'd0, 8'h01, 1, 3'd0, 1);
      cyc("load_wrap_target", 1, 1, 1, 1, 0, 3'd0, 8'h01, 1, 3'd0, 0);

      // 5: en=0 while scanning, en=1 without load, en=0 beats load
      cyc("scan_load3", 1, 1, 1, 1, 0, 3'd3, 8'h08, 1, 3'd3, 0);
      cyc("en_off", 1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 3'd3, 0);
      hold("en_on_no_load", 3, 0, 8'h00, 0, 3'd3);
      cyc("en_off_beats_load", 1, 0, 1, 0, 0, 3'd2, 8'h00, 0, 3'd3, 0);
      hold("idle_again", 1, 0, 8'h00, 0, 3'd3);

      // 6: reload exactly at div==3 suppresses the step; then reset mid-scan
      cyc("rl_load3", 1, 1, 1, 1, 0, 3'd3, 8'h08, 1, 3'd3, 0);
      hold("rl_dwell_a", 3, 0, 8'h08, 1, 3'd3);
      cyc("rl_reload3", 1, 1, 1, 1, 0, 3'd3, 8'h08, 1, 3'd3, 0);
      hold("rl_dwell_b", 3, 0, 8'h08, 1, 3'd3);
      cyc("rl_step4", 1, 1, 0, 0, 0, 3'd0, 8'h10, 1, 3'd4, 0);
      hold("rl_dwell4", 2, 0, 8'h10, 1, 3'd4);
      cyc("reset_mid_scan", 0, 1, 0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0);
      hold("idle_post_reset", 5, 0, 8'h00, 0, 3'd0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
